// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: constant clog2 and the storage-style names.
package fifo_pkg;

    localparam string MEM_AUTO  = "auto";
    localparam string MEM_DIST  = "distributed";
    localparam string MEM_BLOCK = "block";

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_rst_busy_gen.sv
// Reset-busy generator: a shift register preset by rst that drains one stage per clock.
module fifo_rst_busy_gen #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_wr_rst_busy,
    output logic o_rd_rst_busy
);

    logic [SYNC_STAGES-1:0] r_busy_sr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_busy_sr <= '1;
        else       r_busy_sr <= {r_busy_sr[SYNC_STAGES-2:0], 1'b0};
    end

    // Both sides share one clock, so one chain serves both flags.
    assign o_wr_rst_busy = r_busy_sr[SYNC_STAGES-1];
    assign o_rd_rst_busy = r_busy_sr[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_sc_fwft.sv
// Single-clock first-word-fall-through FIFO with reset-busy flags.
module fifo_sc_fwft
    import fifo_pkg::*;
#(
    parameter int    DATA_WIDTH  = 32,
    parameter int    DEPTH       = 32,
    parameter string MEMTYPE     = "auto",
    parameter int    SYNC_STAGES = 2,
    localparam int   AW          = clog2_f(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           data_count,
    output logic                  wr_rst_busy,
    output logic                  rd_rst_busy
);

    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [AW:0]           r_count;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_busy, w_rd_busy, w_cnt_full, w_cnt_empty, w_wr_acc, w_rd_acc;

    fifo_rst_busy_gen #(.SYNC_STAGES(SYNC_STAGES)) u_busy (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_wr_rst_busy (w_busy),
        .o_rd_rst_busy (w_rd_busy)
    );

    assign w_cnt_full  = (r_count == (AW+1)'(DEPTH));
    assign w_cnt_empty = (r_count == '0);
    // Full is judged on the pre-pop count, so push+pop on a full FIFO drops the push.
    assign w_wr_acc    = wr_en & ~w_cnt_full  & ~w_busy;
    assign w_rd_acc    = rd_en & ~w_cnt_empty & ~w_rd_busy;

    generate
        if (MEMTYPE == MEM_BLOCK) begin : g_block
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) if (w_wr_acc) r_mem[r_wr_ptr] <= din;
            assign w_head = r_mem[r_rd_ptr];
        end else if (MEMTYPE == MEM_DIST) begin : g_dist
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) if (w_wr_acc) r_mem[r_wr_ptr] <= din;
            assign w_head = r_mem[r_rd_ptr];
        end else begin : g_auto
            logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) if (w_wr_acc) r_mem[r_wr_ptr] <= din;
            assign w_head = r_mem[r_rd_ptr];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_hold   <= w_head;
            end
            if (w_wr_acc && !w_rd_acc)      r_count <= r_count + (AW+1)'(1);
            else if (w_rd_acc && !w_wr_acc) r_count <= r_count - (AW+1)'(1);
        end
    end

    // While empty, show the last popped word (0 after reset) instead of a stale slot.
    assign dout        = w_cnt_empty ? r_hold : w_head;
    assign empty       = w_cnt_empty;
    assign full        = w_cnt_full | w_busy;
    assign data_count  = r_count;
    assign wr_rst_busy = w_busy;
    assign rd_rst_busy = w_rd_busy;

endmodule

// File: tb/tb_fifo_sc_fwft.sv
// Randomized + directed bench for fifo_sc_fwft against a queue-based reference model.
module tb_fifo_sc_fwft;

    localparam int DW = 32;
    localparam int DEPTH = 32;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          wr_en = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] dout;
    logic          full, empty, wr_rst_busy, rd_rst_busy;
    logic [5:0]    data_count;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_last = '0;
    int            since = 0;

    fifo_sc_fwft #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MEMTYPE("auto"), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout),
        .full(full), .empty(empty), .data_count(data_count),
        .wr_rst_busy(wr_rst_busy), .rd_rst_busy(rd_rst_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '0;
        since  = 0;
    endtask

    // One rising edge of the reference: busy gates everything, full/empty judged before the edge.
    task automatic model_edge();
        bit busy, wok, rok;
        if (rst) return;
        busy = (since < SYNC);
        if (!busy) begin
            wok = wr_en && (q.size() < DEPTH);
            rok = rd_en && (q.size() > 0);
            if (rok) m_last = q.pop_front();
            if (wok) q.push_back(din);
        end
        if (since < SYNC) since++;
    endtask

    task automatic check_all();
        bit busy;
        busy = (since < SYNC);
        chk("wr_rst_busy", 64'(wr_rst_busy), 64'(busy));
        chk("rd_rst_busy", 64'(rd_rst_busy), 64'(busy));
        chk("full",        64'(full),  64'(busy || q.size() == DEPTH));
        chk("empty",       64'(empty), 64'(q.size() == 0));
        chk("data_count",  64'(data_count), 64'(q.size()));
        chk("dout",        64'(dout), 64'(q.size() > 0 ? q[0] : m_last));
    endtask

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en = w; din = d; rd_en = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_rst();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full",  64'(full),  64'd1);
        chk("rst_busy",  64'(wr_rst_busy & rd_rst_busy), 64'd1);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset and busy release
        #28;
        check_all();
        chk("t1_dout0", 64'(dout), 64'd0);
        rst = 1'b0;
        cyc(1'b1, 32'h1111, 1'b1);           // ignored while busy
        chk("t1_busy_e1", 64'(wr_rst_busy), 64'd1);
        cyc(1'b0, '0, 1'b0);
        chk("t1_busy_e2", 64'(wr_rst_busy), 64'd0);
        chk("t1_full_e2", 64'(full), 64'd0);
        cyc(1'b0, '0, 1'b0);
        chk("t1_cnt", 64'(data_count), 64'd0);

        // 2: single word fall-through
        cyc(1'b1, 32'hA5, 1'b0);
        chk("t2_dout", 64'(dout), 64'hA5);
        chk("t2_empty", 64'(empty), 64'd0);
        cyc(1'b0, '0, 1'b1);
        chk("t2_empty_pop", 64'(empty), 64'd1);
        chk("t2_hold", 64'(dout), 64'hA5);

        // 3: fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i), 1'b0);
        chk("t3_full", 64'(full), 64'd1);
        cyc(1'b1, 32'hFF, 1'b0);
        chk("t3_ovf_cnt", 64'(data_count), 64'd32);
        // 4a: push+pop while full: only the pop lands
        cyc(1'b1, 32'hDEAD, 1'b1);
        chk("t4_cnt31", 64'(data_count), 64'd31);
        chk("t4_head", 64'(dout), 64'd1);
        for (int i = 1; i < DEPTH; i++) begin
            chk("t3_order", 64'(dout), 64'(i));
            cyc(1'b0, '0, 1'b1);
        end
        chk("t3_drained", 64'(empty), 64'd1);

        // 4b: half-full push+pop keeps count and order
        for (int i = 0; i < 16; i++) cyc(1'b1, DW'(100 + i), 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, DW'(200 + i), 1'b1);
        chk("t4_cnt16", 64'(data_count), 64'd16);
        chk("t4_order", 64'(dout), 64'd104);
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);

        // 5: underflow, and push+pop while empty
        cyc(1'b0, '0, 1'b1);
        chk("t5_uflow", 64'(data_count), 64'd0);
        cyc(1'b1, 32'h5A5A, 1'b1);
        chk("t5_pushpop", 64'(data_count), 64'd1);
        chk("t5_dout", 64'(dout), 64'h5A5A);

        // 6: async reset holding 10 words
        for (int i = 0; i < 9; i++) cyc(1'b1, DW'(32'hC0 + i), 1'b0);
        #2;
        async_rst();
        for (int i = 0; i < SYNC + 2; i++) cyc(1'b0, '0, 1'b1);
        chk("t6_cnt", 64'(data_count), 64'd0);
        cyc(1'b1, 32'h77, 1'b0);
        chk("t6_new", 64'(dout), 64'h77);

        // random traffic with varying fill bias and one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 300) % 2 == 0) ? 70 : 30;
            if (i == 1500) async_rst();
            cyc(($urandom_range(99) < bias), $urandom, ($urandom_range(99) >= bias - 20));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
